// File: rtl/layer_pkg.sv
// Shared types and constants for the compositing layer chain.
package layer_pkg;

  localparam int unsigned LAYER_DEPTH   = 4;
  localparam int unsigned LAYER_LATENCY = 2;

  typedef struct packed {
    logic [LAYER_DEPTH-1:0] r;
    logic [LAYER_DEPTH-1:0] g;
    logic [LAYER_DEPTH-1:0] b;
    logic                   a;
  } rgba_t;

  // Texel words are {R,G,B,A} with alpha in the LSB, which is exactly the packed struct order.
  function automatic rgba_t unpack_rgba(input logic [3*LAYER_DEPTH:0] data);
    return rgba_t'(data);
  endfunction

endpackage

// File: rtl/anim_sprite_addr.sv
// Stage-0 sprite address generation with frame-start double-buffered placement and animation.
module anim_sprite_addr
  import layer_pkg::*;
#(
  parameter int unsigned HWIDTH      = 12,
  parameter int unsigned VWIDTH      = 12,
  parameter int unsigned SPR_W       = 160,
  parameter int unsigned SPR_H       = 120,
  parameter int unsigned NFRAMES     = 4,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned PWIDTH      = 8,
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned FIDX_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  frame_start_i,
  input  logic [HWIDTH-1:0]     hdata_i,
  input  logic [VWIDTH-1:0]     vdata_i,
  input  logic [HWIDTH-1:0]     hoffset_i,
  input  logic [VWIDTH-1:0]     voffset_i,
  input  logic                  flip_h_i,
  input  logic                  anim_en_i,
  input  logic [PWIDTH-1:0]     anim_period_i,
  input  logic                  anim_restart_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  hit_o,
  output logic [FIDX_WIDTH-1:0] frame_idx_o
);

  localparam int unsigned UWidth     = $clog2(SPR_W);
  localparam int unsigned VWidthT    = $clog2(SPR_H);
  localparam int unsigned FrameWords = SPR_W * SPR_H;

  logic [HWIDTH-1:0]     hoff_q, hoff_d;
  logic [VWIDTH-1:0]     voff_q, voff_d;
  logic                  flip_q, flip_d;
  logic [PWIDTH-1:0]     anim_cnt_q, anim_cnt_d;
  logic [FIDX_WIDTH-1:0] frame_idx_q, frame_idx_d;

  logic [HWIDTH:0]       sx;
  logic [VWIDTH:0]       sy;
  logic                  hit_x, hit_y;
  logic [UWidth-1:0]     u_raw, u;
  logic [VWidthT-1:0]    v;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hoff_q      <= '0;
      voff_q      <= '0;
      flip_q      <= 1'b0;
      anim_cnt_q  <= '0;
      frame_idx_q <= '0;
    end else begin
      hoff_q      <= hoff_d;
      voff_q      <= voff_d;
      flip_q      <= flip_d;
      anim_cnt_q  <= anim_cnt_d;
      frame_idx_q <= frame_idx_d;
    end
  end

  always_comb begin
    hoff_d      = hoff_q;
    voff_d      = voff_q;
    flip_d      = flip_q;
    anim_cnt_d  = anim_cnt_q;
    frame_idx_d = frame_idx_q;
    if (frame_start_i) begin
      hoff_d = hoffset_i;
      voff_d = voffset_i;
      flip_d = flip_h_i;
      if (anim_en_i) begin
        if (anim_cnt_q == anim_period_i) begin
          anim_cnt_d  = '0;
          frame_idx_d = (frame_idx_q == FIDX_WIDTH'(NFRAMES - 1)) ? '0
                                                                   : frame_idx_q + FIDX_WIDTH'(1);
        end else begin
          anim_cnt_d = anim_cnt_q + PWIDTH'(1);
        end
      end
    end
    // Restart wins over any advance but never blocks the placement latch.
    if (anim_restart_i) begin
      anim_cnt_d  = '0;
      frame_idx_d = '0;
    end
  end

  always_comb begin
    sx    = {1'b0, hdata_i} - {hoff_q[HWIDTH-1], hoff_q};
    sy    = {1'b0, vdata_i} - {voff_q[VWIDTH-1], voff_q};
    hit_x = !sx[HWIDTH] && (sx[HWIDTH-1:0] < HWIDTH'(SPR_W << SCALE_SHIFT));
    hit_y = !sy[VWIDTH] && (sy[VWIDTH-1:0] < VWIDTH'(SPR_H << SCALE_SHIFT));
    hit_o = hit_x & hit_y;
    u_raw = sx[SCALE_SHIFT +: UWidth];
    u     = flip_q ? UWidth'(SPR_W - 1) - u_raw : u_raw;
    v     = sy[SCALE_SHIFT +: VWidthT];
    // Misses are forced to address 0 so the VRAM never sees an out-of-range index.
    addr_o = hit_o ? ADDR_WIDTH'(frame_idx_q) * ADDR_WIDTH'(FrameWords)
                     + ADDR_WIDTH'(v) * ADDR_WIDTH'(SPR_W) + ADDR_WIDTH'(u)
                   : '0;
  end

  assign frame_idx_o = frame_idx_q;

endmodule

// File: rtl/sprite_rom.sv
// Synchronous sprite VRAM: one registered read port, contents loaded outside this block.
module sprite_rom #(
  parameter int unsigned DATA_WIDTH = 13,
  parameter int unsigned SIZE       = 76800,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (en_i) data_q <= mem[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/anim_sprite_layer.sv
// Animated, scaled, mirrorable sprite layer with a fixed two-cycle pixel latency.
module anim_sprite_layer
  import layer_pkg::*;
#(
  parameter int unsigned DEPTH       = LAYER_DEPTH,
  parameter int unsigned HWIDTH      = 12,
  parameter int unsigned VWIDTH      = 12,
  parameter int unsigned SPR_W       = 160,
  parameter int unsigned SPR_H       = 120,
  parameter int unsigned NFRAMES     = 4,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned PWIDTH      = 8,
  parameter int unsigned DATA_WIDTH  = 3 * DEPTH + 1,
  parameter int unsigned SIZE        = SPR_W * SPR_H * NFRAMES,
  parameter int unsigned ADDR_WIDTH  = $clog2(SIZE),
  parameter int unsigned FIDX_WIDTH  = (NFRAMES > 1) ? $clog2(NFRAMES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [HWIDTH-1:0]     hdata,
  input  logic [VWIDTH-1:0]     vdata,
  input  logic [HWIDTH-1:0]     hoffset,
  input  logic [VWIDTH-1:0]     voffset,
  input  logic                  flip_h,
  input  logic                  anim_en,
  input  logic [PWIDTH-1:0]     anim_period,
  input  logic                  anim_restart,
  input  logic [DEPTH-1:0]      R_prev,
  input  logic [DEPTH-1:0]      G_prev,
  input  logic [DEPTH-1:0]      B_prev,
  input  logic                  A_prev,
  output logic [DEPTH-1:0]      R_next,
  output logic [DEPTH-1:0]      G_next,
  output logic [DEPTH-1:0]      B_next,
  output logic                  A_next,
  output logic [FIDX_WIDTH-1:0] frame_idx
);

  logic [ADDR_WIDTH-1:0] addr, addr_q1;
  logic                  hit, hit_q1, hit_q2;
  logic [DATA_WIDTH-1:0] rom_data;
  rgba_t                 prev_q [LAYER_LATENCY];
  rgba_t                 texel;
  logic                  draw;

  anim_sprite_addr #(
    .HWIDTH      (HWIDTH),
    .VWIDTH      (VWIDTH),
    .SPR_W       (SPR_W),
    .SPR_H       (SPR_H),
    .NFRAMES     (NFRAMES),
    .SCALE_SHIFT (SCALE_SHIFT),
    .PWIDTH      (PWIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .FIDX_WIDTH  (FIDX_WIDTH)
  ) u_addr (
    .clk_i          (clk),
    .rst_i          (rst),
    .frame_start_i  (frame_start),
    .hdata_i        (hdata),
    .vdata_i        (vdata),
    .hoffset_i      (hoffset),
    .voffset_i      (voffset),
    .flip_h_i       (flip_h),
    .anim_en_i      (anim_en),
    .anim_period_i  (anim_period),
    .anim_restart_i (anim_restart),
    .addr_o         (addr),
    .hit_o          (hit),
    .frame_idx_o    (frame_idx)
  );

  sprite_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rom (
    .clk_i  (clk),
    .en_i   (hit_q1),
    .addr_i (addr_q1),
    .data_o (rom_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q1 <= '0;
      hit_q1  <= 1'b0;
      hit_q2  <= 1'b0;
      for (int i = 0; i < LAYER_LATENCY; i++) prev_q[i] <= '0;
    end else begin
      addr_q1   <= addr;
      hit_q1    <= hit;
      hit_q2    <= hit_q1;
      prev_q[0] <= rgba_t'({R_prev, G_prev, B_prev, A_prev});
      for (int i = 1; i < LAYER_LATENCY; i++) prev_q[i] <= prev_q[i-1];
    end
  end

  always_comb begin
    texel  = unpack_rgba(rom_data);
    draw   = hit_q2 & texel.a;
    R_next = draw ? texel.r : prev_q[LAYER_LATENCY-1].r;
    G_next = draw ? texel.g : prev_q[LAYER_LATENCY-1].g;
    B_next = draw ? texel.b : prev_q[LAYER_LATENCY-1].b;
    A_next = prev_q[LAYER_LATENCY-1].a | draw;
  end

endmodule

// File: tb/tb_anim_sprite_layer.sv
// Scoreboard bench for anim_sprite_layer: a pixel-level model predicts each output two cycles out.
module tb_anim_sprite_layer;

  localparam int SprW       = 160;
  localparam int SprH       = 120;
  localparam int FrameWords = SprW * SprH;
  localparam int Size       = FrameWords * 4;
  localparam int Keep       = 99999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [11:0] hdata = '0, vdata = '0, hoffset = '0, voffset = '0;
  logic        flip_h = 1'b0, anim_en = 1'b0, anim_restart = 1'b0;
  logic [7:0]  anim_period = '0;
  logic [3:0]  R_prev = '0, G_prev = '0, B_prev = '0;
  logic        A_prev = 1'b0;
  logic [3:0]  R_next, G_next, B_next;
  logic        A_next;
  logic [1:0]  frame_idx;

  always #5 clk = ~clk;

  anim_sprite_layer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .hdata        (hdata),
    .vdata        (vdata),
    .hoffset      (hoffset),
    .voffset      (voffset),
    .flip_h       (flip_h),
    .anim_en      (anim_en),
    .anim_period  (anim_period),
    .anim_restart (anim_restart),
    .R_prev       (R_prev),
    .G_prev       (G_prev),
    .B_prev       (B_prev),
    .A_prev       (A_prev),
    .R_next       (R_next),
    .G_next       (G_next),
    .B_next       (B_next),
    .A_next       (A_next),
    .frame_idx    (frame_idx)
  );

  typedef struct {
    logic        fs;
    logic        rs;
    int          hoff;
    int          h;
    int          v;
    logic [12:0] prev;
  } stim_t;

  logic [12:0] tex [Size];
  logic [12:0] sbq [$];
  int n_cmp = 0;
  int n_err = 0;
  int m_hoff, m_voff, m_cnt, m_idx;
  bit m_flip;

  function automatic stim_t mk(input logic fs, input logic rs, input int hoff, input int h,
                               input int v, input logic [12:0] prev);
    stim_t s;
    s.fs = fs; s.rs = rs; s.hoff = hoff; s.h = h; s.v = v; s.prev = prev;
    return s;
  endfunction

  function automatic int sext12(input logic [11:0] x);
    return x[11] ? int'(x) - 4096 : int'(x);
  endfunction

  function automatic logic [12:0] model_out(input int h, input int v, input logic [12:0] prev);
    int sx, sy, u, a;
    logic [12:0] t;
    sx = h - m_hoff;
    sy = v - m_voff;
    if (sx < 0 || sx >= SprW * 4 || sy < 0 || sy >= SprH * 4) return prev;
    u = sx / 4;
    if (m_flip) u = SprW - 1 - u;
    a = m_idx * FrameWords + (sy / 4) * SprW + u;
    t = tex[a];
    return t[0] ? t : prev;
  endfunction

  task automatic model_reset();
    m_hoff = 0; m_voff = 0; m_cnt = 0; m_idx = 0; m_flip = 1'b0;
  endtask

  task automatic load_texel(input int a, input logic [12:0] t);
    tex[a] = t;
    dut.u_rom.mem[a] = t;
  endtask

  // Drives one pixel cycle, pushes its expected output, then advances the model past this edge.
  task automatic drive_pixel(input stim_t s);
    if (s.hoff != Keep) hoffset = 12'(s.hoff);
    frame_start  = s.fs;
    anim_restart = s.rs;
    hdata = 12'(s.h);
    vdata = 12'(s.v);
    {R_prev, G_prev, B_prev, A_prev} = s.prev;
    sbq.push_back(model_out(s.h, s.v, s.prev));
    if (s.fs) begin
      m_hoff = sext12(hoffset);
      m_voff = sext12(voffset);
      m_flip = flip_h;
    end
    if (s.rs) begin
      m_cnt = 0; m_idx = 0;
    end else if (s.fs && anim_en) begin
      if (m_cnt == int'(anim_period)) begin
        m_cnt = 0; m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    stim_t st[$];
    stim_t idle;
    logic [12:0] exp, got;
    idle = mk(1'b0, 1'b0, Keep, 4000, 4000, 13'h0);
    anim_en = 1'b1; anim_period = 8'd0; hoffset = '0; voffset = '0;
    st.push_back(mk(1'b1, 1'b0, Keep, 1000, 10, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 0, 0, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 1000, 10, {4'h7, 4'h8, 4'h9, 1'b1}));
    for (int i = 0; i < st.size() + 2; i++) begin
      @(negedge clk);
      if (sbq.size() == 2) begin
        exp = sbq.pop_front(); got = {R_next, G_next, B_next, A_next}; n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL reset_pre[%0d]: got %h want %h", i, got, exp);
        end
      end
      if (i < st.size()) drive_pixel(st[i]); else drive_pixel(idle);
    end
    n_cmp++;
    if (frame_idx !== 2'd1) begin
      n_err++; $display("FAIL reset_pre_idx: got %0d want 1", frame_idx);
    end
    @(negedge clk);
    rst = 1'b1; anim_en = 1'b0;
    sbq.delete();
    model_reset();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_cmp++;
      if ({R_next, G_next, B_next, A_next, frame_idx} !== 15'h0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got out %h idx %0d want 0", c,
                 {R_next, G_next, B_next, A_next}, frame_idx);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive_pixel(mk(1'b0, 1'b0, Keep, 1000, 10, {4'h7, 4'h8, 4'h9, 1'b1}));
    @(negedge clk);
    n_cmp++;
    if ({R_next, G_next, B_next, A_next} !== 13'h0) begin
      n_err++; $display("FAIL reset_early: got %h want 0", {R_next, G_next, B_next, A_next});
    end
    drive_pixel(idle);
    @(negedge clk);
    n_cmp++;
    if ({R_next, G_next, B_next, A_next} !== {4'h7, 4'h8, 4'h9, 1'b1}) begin
      n_err++; $display("FAIL reset_first: got %h want %h", {R_next, G_next, B_next, A_next},
                        {4'h7, 4'h8, 4'h9, 1'b1});
    end
    sbq.delete();
  endtask

  task automatic test_basic();
    stim_t st[$];
    stim_t idle;
    logic [12:0] exp, got;
    idle = mk(1'b0, 1'b0, Keep, 4000, 4000, 13'h0);
    voffset = 12'd50; flip_h = 1'b0;
    st.push_back(mk(1'b1, 1'b0, 100, 4000, 4000, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 100, 50, {4'h1, 4'h2, 4'h3, 1'b0}));
    st.push_back(mk(1'b0, 1'b0, Keep, 99, 50, {4'h6, 4'h5, 4'h4, 1'b1}));
    st.push_back(mk(1'b0, 1'b0, Keep, 103, 53, {4'h6, 4'h5, 4'h4, 1'b0}));
    st.push_back(mk(1'b0, 1'b0, Keep, 739, 50, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 740, 50, {4'h2, 4'h2, 4'h2, 1'b1}));
    st.push_back(mk(1'b0, 1'b0, Keep, 100, 529, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 100, 530, {4'h3, 4'h3, 4'h3, 1'b0}));
    st.push_back(mk(1'b0, 1'b0, Keep, 100, 49, {4'h4, 4'h4, 4'h4, 1'b1}));
    for (int i = 0; i < st.size() + 2; i++) begin
      @(negedge clk);
      if (sbq.size() == 2) begin
        exp = sbq.pop_front(); got = {R_next, G_next, B_next, A_next}; n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL basic[%0d]: got %h want %h", i, got, exp);
        end
      end
      if (i < st.size()) drive_pixel(st[i]); else drive_pixel(idle);
    end
    sbq.delete();
  endtask

  task automatic test_alpha();
    stim_t st[$];
    stim_t idle;
    logic [12:0] exp, got;
    idle = mk(1'b0, 1'b0, Keep, 4000, 4000, 13'h0);
    st.push_back(mk(1'b0, 1'b0, Keep, 104, 50, {4'h3, 4'h4, 4'h5, 1'b1}));
    st.push_back(mk(1'b0, 1'b0, Keep, 105, 51, {4'h3, 4'h4, 4'h5, 1'b0}));
    st.push_back(mk(1'b0, 1'b0, Keep, 101, 52, {4'h3, 4'h4, 4'h5, 1'b0}));
    for (int i = 0; i < st.size() + 2; i++) begin
      @(negedge clk);
      if (sbq.size() == 2) begin
        exp = sbq.pop_front(); got = {R_next, G_next, B_next, A_next}; n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL alpha[%0d]: got %h want %h", i, got, exp);
        end
      end
      if (i < st.size()) drive_pixel(st[i]); else drive_pixel(idle);
    end
    sbq.delete();
  endtask

  task automatic test_flip();
    stim_t st[$];
    stim_t idle;
    logic [12:0] exp, got;
    idle = mk(1'b0, 1'b0, Keep, 4000, 4000, 13'h0);
    voffset = 12'd0; flip_h = 1'b1;
    st.push_back(mk(1'b1, 1'b0, 0, 4000, 4000, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 0, 0, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 639, 0, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 4, 0, {4'h8, 4'h8, 4'h8, 1'b0}));
    for (int i = 0; i < st.size() + 2; i++) begin
      @(negedge clk);
      if (sbq.size() == 2) begin
        exp = sbq.pop_front(); got = {R_next, G_next, B_next, A_next}; n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL flip[%0d]: got %h want %h", i, got, exp);
        end
      end
      if (i < st.size()) drive_pixel(st[i]); else drive_pixel(idle);
    end
    sbq.delete();
    st.delete();
    flip_h = 1'b0;
    st.push_back(mk(1'b1, 1'b0, -8, 4000, 4000, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 0, 0, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 4, 0, {4'h6, 4'h6, 4'h6, 1'b1}));
    for (int i = 0; i < st.size() + 2; i++) begin
      @(negedge clk);
      if (sbq.size() == 2) begin
        exp = sbq.pop_front(); got = {R_next, G_next, B_next, A_next}; n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL negoff[%0d]: got %h want %h", i, got, exp);
        end
      end
      if (i < st.size()) drive_pixel(st[i]); else drive_pixel(idle);
    end
    sbq.delete();
  endtask

  task automatic test_hoff_change();
    stim_t st[$];
    stim_t idle;
    logic [12:0] exp, got;
    idle = mk(1'b0, 1'b0, Keep, 4000, 4000, 13'h0);
    voffset = 12'd50;
    st.push_back(mk(1'b1, 1'b0, 100, 4000, 4000, 13'h0));
    st.push_back(mk(1'b0, 1'b0, 300, 100, 50, {4'h5, 4'h5, 4'h5, 1'b0}));
    st.push_back(mk(1'b0, 1'b0, Keep, 300, 50, {4'h5, 4'h5, 4'h5, 1'b0}));
    st.push_back(mk(1'b1, 1'b0, Keep, 4000, 4000, 13'h0));
    st.push_back(mk(1'b0, 1'b0, Keep, 100, 50, {4'h5, 4'h5, 4'h5, 1'b0}));
    st.push_back(mk(1'b0, 1'b0, Keep, 300, 50, {4'h5, 4'h5, 4'h5, 1'b0}));
    for (int i = 0; i < st.size() + 2; i++) begin
      @(negedge clk);
      if (sbq.size() == 2) begin
        exp = sbq.pop_front(); got = {R_next, G_next, B_next, A_next}; n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL hoff_change[%0d]: got %h want %h", i, got, exp);
        end
      end
      if (i < st.size()) drive_pixel(st[i]); else drive_pixel(idle);
    end
    sbq.delete();
  endtask

  task automatic test_anim();
    stim_t st[$];
    stim_t idle;
    logic [12:0] exp, got;
    int want_idx [17] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1, 0, 0};
    int k = 0;
    idle = mk(1'b0, 1'b0, Keep, 4000, 4000, 13'h0);
    voffset = 12'd50; anim_en = 1'b1; anim_period = 8'd2;
    for (int f = 0; f < 17; f++) begin
      if (f == 15) st.push_back(mk(1'b1, 1'b1, 200, 4000, 4000, 13'h0));
      else st.push_back(mk(1'b1, 1'b0, 100, 200, 50, {4'hC, 4'hC, 4'hC, 1'b0}));
      st.push_back(mk(1'b0, 1'b0, Keep, (f >= 15) ? 200 : 100, 50, {4'hD, 4'hD, 4'hD, 1'b0}));
    end
    for (int i = 0; i < st.size() + 2; i++) begin
      @(negedge clk);
      if (sbq.size() == 2) begin
        exp = sbq.pop_front(); got = {R_next, G_next, B_next, A_next}; n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL anim_pix[%0d]: got %h want %h", i, got, exp);
        end
      end
      if (i >= 1 && i - 1 < st.size() && st[i-1].fs && k < 17) begin
        n_cmp++;
        if (int'(frame_idx) != want_idx[k]) begin
          n_err++; $display("FAIL anim_idx[%0d]: got %0d want %0d", k, frame_idx, want_idx[k]);
        end
        k++;
      end
      if (i < st.size()) drive_pixel(st[i]); else drive_pixel(idle);
    end
    sbq.delete();
    anim_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < Size; i++) begin
      tex[i] = '0;
      dut.u_rom.mem[i] = '0;
    end
    load_texel(0, 13'h1FFF);
    load_texel(1, {4'hF, 4'h0, 4'h0, 1'b0});
    load_texel(2, {4'hA, 4'hB, 4'hC, 1'b1});
    load_texel(159, {4'h1, 4'h2, 4'h3, 1'b1});
    load_texel(119 * SprW, {4'h1, 4'h1, 4'h1, 1'b1});
    load_texel(FrameWords, {4'h9, 4'h9, 4'h9, 1'b1});
    load_texel(2 * FrameWords, {4'h5, 4'h6, 4'h7, 1'b1});
    load_texel(3 * FrameWords, {4'h2, 4'h2, 4'h2, 1'b1});
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_alpha();
    test_flip();
    test_hoff_change();
    test_anim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
